// File: rtl/mpe_out2in_accum.sv
// Scatters output-space tiles into an input-space accumulator across a kernel sweep.
// Define MPE_OUT2IN_SAT_EN to make each element addition saturate instead of wrap.

`ifndef BIN_LEN
`define BIN_LEN 16
`endif
`ifndef OUTPUT_HEIGHT
`define OUTPUT_HEIGHT 4
`endif
`ifndef OUTPUT_WIDTH
`define OUTPUT_WIDTH 4
`endif
`ifndef INPUT_HEIGHT
`define INPUT_HEIGHT 6
`endif
`ifndef INPUT_WIDTH
`define INPUT_WIDTH 6
`endif
`ifndef KERNEL_HEIGHT
`define KERNEL_HEIGHT 3
`endif
`ifndef KERNEL_WIDTH
`define KERNEL_WIDTH 3
`endif

module mpe_out2in_accum #(
  parameter int BIN_LEN = `BIN_LEN,
  parameter int OUT_H   = `OUTPUT_HEIGHT,
  parameter int OUT_W   = `OUTPUT_WIDTH,
  parameter int IN_H    = `INPUT_HEIGHT,
  parameter int IN_W    = `INPUT_WIDTH,
  parameter int K_H     = `KERNEL_HEIGHT,
  parameter int K_W     = `KERNEL_WIDTH
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [$clog2(K_H):0]           kernel_height,
  input  logic [$clog2(K_W):0]           kernel_width,
  input  logic [2:0]                     stride,
  input  logic [BIN_LEN*OUT_H*OUT_W-1:0] out_vals,
  input  logic                           out_valid,
  output logic                           out_ready,
  output logic [BIN_LEN*IN_H*IN_W-1:0]   in_vals,
  output logic                           in_valid,
  input  logic                           in_ready,
  output logic                           busy
);

  localparam int KHW = $clog2(K_H) + 1;
  localparam int KWW = $clog2(K_W) + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                    state_q, state_d;
  logic [KHW-1:0]            kh_q, kh_d, kh_cfg_q, kh_cfg_d;
  logic [KWW-1:0]            kw_q, kw_d, kw_cfg_q, kw_cfg_d;
  logic [2:0]                stride_q, stride_d;
  logic signed [BIN_LEN-1:0] acc_q [IN_H][IN_W];
  logic signed [BIN_LEN-1:0] acc_d [IN_H][IN_W];
  logic                      out_ready_q, out_ready_d;
  logic                      in_valid_q, in_valid_d;
  logic                      busy_q, busy_d;
  logic                      hit;
  logic signed [BIN_LEN-1:0] addend;

  function automatic logic signed [BIN_LEN-1:0] add_elem(
    input logic signed [BIN_LEN-1:0] a,
    input logic signed [BIN_LEN-1:0] b
  );
`ifdef MPE_OUT2IN_SAT_EN
    logic signed [BIN_LEN:0] sum;
    sum = {a[BIN_LEN-1], a} + {b[BIN_LEN-1], b};
    // Top two bits disagree only on overflow; the true sign picks the rail.
    if (sum[BIN_LEN] != sum[BIN_LEN-1])
      return sum[BIN_LEN] ? {1'b1, {(BIN_LEN-1){1'b0}}} : {1'b0, {(BIN_LEN-1){1'b1}}};
    return sum[BIN_LEN-1:0];
`else
    return a + b;
`endif
  endfunction

  function automatic logic [KHW-1:0] clamp_h(input logic [KHW-1:0] v);
    if (v == '0) return KHW'(1);
    if (v > KHW'(K_H)) return KHW'(K_H);
    return v;
  endfunction

  function automatic logic [KWW-1:0] clamp_w(input logic [KWW-1:0] v);
    if (v == '0) return KWW'(1);
    if (v > KWW'(K_W)) return KWW'(K_W);
    return v;
  endfunction

  always_comb begin
    state_d  = state_q;
    kh_d     = kh_q;
    kw_d     = kw_q;
    kh_cfg_d = kh_cfg_q;
    kw_cfg_d = kw_cfg_q;
    stride_d = stride_q;
    acc_d    = acc_q;
    hit      = 1'b0;
    addend   = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ACCUM;
          kh_cfg_d = clamp_h(kernel_height);
          kw_cfg_d = clamp_w(kernel_width);
          stride_d = (stride == 3'd0) ? 3'd1 : stride;
          kh_d     = '0;
          kw_d     = '0;
          for (int r = 0; r < IN_H; r++)
            for (int c = 0; c < IN_W; c++)
              acc_d[r][c] = '0;
        end
      end
      ACCUM: begin
        if (out_valid) begin
          // Gather form: each target finds the at-most-one source landing on it.
          for (int r = 0; r < IN_H; r++) begin
            for (int c = 0; c < IN_W; c++) begin
              hit    = 1'b0;
              addend = '0;
              for (int i = 0; i < OUT_H; i++) begin
                for (int j = 0; j < OUT_W; j++) begin
                  if ((i * int'(stride_q) + int'(kh_q) == r) &&
                      (j * int'(stride_q) + int'(kw_q) == c)) begin
                    hit    = 1'b1;
                    addend = out_vals[(i*OUT_W+j)*BIN_LEN +: BIN_LEN];
                  end
                end
              end
              if (hit) acc_d[r][c] = add_elem(acc_q[r][c], addend);
            end
          end
          if (kw_q == kw_cfg_q - KWW'(1)) begin
            kw_d = '0;
            if (kh_q == kh_cfg_q - KHW'(1)) begin
              kh_d    = '0;
              state_d = DONE;
            end else begin
              kh_d = kh_q + KHW'(1);
            end
          end else begin
            kw_d = kw_q + KWW'(1);
          end
        end
      end
      DONE: begin
        if (in_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    out_ready_d = (state_d == ACCUM);
    in_valid_d  = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      kh_q        <= '0;
      kw_q        <= '0;
      kh_cfg_q    <= KHW'(1);
      kw_cfg_q    <= KWW'(1);
      stride_q    <= 3'd1;
      out_ready_q <= 1'b0;
      in_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      for (int r = 0; r < IN_H; r++)
        for (int c = 0; c < IN_W; c++)
          acc_q[r][c] <= '0;
    end else begin
      state_q     <= state_d;
      kh_q        <= kh_d;
      kw_q        <= kw_d;
      kh_cfg_q    <= kh_cfg_d;
      kw_cfg_q    <= kw_cfg_d;
      stride_q    <= stride_d;
      out_ready_q <= out_ready_d;
      in_valid_q  <= in_valid_d;
      busy_q      <= busy_d;
      acc_q       <= acc_d;
    end
  end

  always_comb begin
    in_vals = '0;
    for (int r = 0; r < IN_H; r++)
      for (int c = 0; c < IN_W; c++)
        in_vals[(r*IN_W+c)*BIN_LEN +: BIN_LEN] = acc_q[r][c];
  end

  assign out_ready = out_ready_q;
  assign in_valid  = in_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mpe_out2in_accum.sv
// Testbench for mpe_out2in_accum: scoreboard of expected accumulator tiles
// built from an independent scatter model, checked when the DUT presents a result.
`timescale 1ns/1ps

module tb_mpe_out2in_accum;

  localparam int BL = 16;
  localparam int OH = 4;
  localparam int OW = 4;
  localparam int IH = 6;
  localparam int IW = 6;
  localparam int KH = 3;
  localparam int KW = 3;
  localparam int TW = BL*OH*OW;
  localparam int AW = BL*IH*IW;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    kernel_height;
  logic [2:0]    kernel_width;
  logic [2:0]    stride;
  logic [TW-1:0] out_vals;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] in_vals;
  logic          in_valid;
  logic          in_ready;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  logic signed [BL-1:0] m_acc [IH][IW];
  logic [AW-1:0]        exp_q [$];
  logic [AW-1:0]        got;
  logic [AW-1:0]        expv;
  logic                 got_ok;

  mpe_out2in_accum #(
    .BIN_LEN(BL), .OUT_H(OH), .OUT_W(OW), .IN_H(IH), .IN_W(IW), .K_H(KH), .K_W(KW)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .kernel_height(kernel_height), .kernel_width(kernel_width), .stride(stride),
    .out_vals(out_vals), .out_valid(out_valid), .out_ready(out_ready),
    .in_vals(in_vals), .in_valid(in_valid), .in_ready(in_ready), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic signed [BL-1:0] m_add(input logic signed [BL-1:0] a,
                                                 input logic signed [BL-1:0] b);
    int s;
    s = int'(a) + int'(b);
`ifdef MPE_OUT2IN_SAT_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`endif
    return BL'(s);
  endfunction

  function automatic logic [BL-1:0] elem(input logic [AW-1:0] v, input int r, input int c);
    return v[(r*IW+c)*BL +: BL];
  endfunction

  function automatic logic [TW-1:0] fill_tile(input logic [BL-1:0] val);
    logic [TW-1:0] t;
    for (int k = 0; k < OH*OW; k++) t[k*BL +: BL] = val;
    return t;
  endfunction

  function automatic logic [TW-1:0] rand_tile();
    logic [TW-1:0] t;
    for (int k = 0; k < OH*OW; k++) t[k*BL +: BL] = BL'($urandom);
    return t;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        m_acc[r][c] = '0;
  endtask

  // Division form: target (r,c) receives source ((r-kh)/s, (c-kw)/s) when aligned.
  task automatic model_apply(input logic [TW-1:0] t, input int kh, input int kw, input int s);
    int dr, dc;
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        dr = r - kh;
        dc = c - kw;
        if (dr >= 0 && dc >= 0 && dr % s == 0 && dc % s == 0 && dr / s < OH && dc / s < OW)
          m_acc[r][c] = m_add(m_acc[r][c], t[((dr/s)*OW + dc/s)*BL +: BL]);
      end
    end
  endtask

  function automatic logic [AW-1:0] model_flat();
    logic [AW-1:0] v;
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        v[(r*IW+c)*BL +: BL] = m_acc[r][c];
    return v;
  endfunction

  task automatic start_pass(input logic [2:0] kh, input logic [2:0] kw, input logic [2:0] s);
    @(negedge clock);
    kernel_height = kh;
    kernel_width  = kw;
    stride        = s;
    start         = 1'b1;
    @(negedge clock);
    start = 1'b0;
    model_clear();
  endtask

  task automatic send_tile(input logic [TW-1:0] t, input bit gap,
                           input int kh, input int kw, input int s);
    bit done;
    if (gap) begin
      out_valid = 1'b0;
      @(negedge clock);
    end
    out_vals  = t;
    out_valid = 1'b1;
    done      = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      if (out_ready) done = 1'b1;
      @(negedge clock);
    end
    out_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL tile_accept_timeout: out_ready got 0 required 1 within 100 cycles");
    end else begin
      model_apply(t, kh, kw, s);
    end
  endtask

  task automatic wait_result(output logic [AW-1:0] v, output logic ok);
    ok = 1'b0;
    v  = 'x;
    for (int n = 0; n < 100 && !ok; n++) begin
      if (in_valid) begin
        ok = 1'b1;
        v  = in_vals;
      end else begin
        @(negedge clock);
      end
    end
  endtask

  task automatic release_result();
    in_ready = 1'b1;
    @(negedge clock);
    in_ready = 1'b0;
  endtask

  task automatic pop_expected(output logic [AW-1:0] v);
    if (exp_q.size() == 0) v = 'x;
    else v = exp_q.pop_front();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_cmp++;
    if (out_ready !== 1'b0) begin n_err++; $display("[TB] FAIL reset_out_ready: got %b required 0", out_ready); end
    n_cmp++;
    if (in_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_in_valid: got %b required 0", in_valid); end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
    n_cmp++;
    if (in_vals !== {AW{1'b0}}) begin n_err++; $display("[TB] FAIL reset_in_vals: got %h required 0", in_vals); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_1x1();
    start_pass(3'd1, 3'd1, 3'd1);
    send_tile(fill_tile(16'd5), 1'b0, 0, 0, 1);
    exp_q.push_back(model_flat());
    n_cmp++;
    if (in_valid !== 1'b1) begin n_err++; $display("[TB] FAIL 1x1_in_valid_latency: got %b required 1", in_valid); end
    wait_result(got, got_ok);
    pop_expected(expv);
    n_cmp++;
    if (!got_ok || got !== expv) begin n_err++; $display("[TB] FAIL 1x1_tile: got %h required %h", got, expv); end
    n_cmp++;
    if (elem(got, 3, 3) !== 16'd5) begin n_err++; $display("[TB] FAIL 1x1_elem33: got %h required 0005", elem(got, 3, 3)); end
    n_cmp++;
    if (elem(got, 4, 5) !== 16'd0) begin n_err++; $display("[TB] FAIL 1x1_elem45: got %h required 0000", elem(got, 4, 5)); end
    release_result();
    n_cmp++;
    if (in_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("[TB] FAIL 1x1_return_idle: got in_valid=%b busy=%b required 0 0", in_valid, busy);
    end
  endtask

  task automatic test_3x3();
    start_pass(3'd3, 3'd3, 3'd1);
    for (int kh = 0; kh < 3; kh++)
      for (int kw = 0; kw < 3; kw++)
        send_tile(fill_tile(16'd1), 1'b0, kh, kw, 1);
    exp_q.push_back(model_flat());
    wait_result(got, got_ok);
    pop_expected(expv);
    n_cmp++;
    if (!got_ok || got !== expv) begin n_err++; $display("[TB] FAIL 3x3_tile: got %h required %h", got, expv); end
    n_cmp++;
    if (elem(got, 2, 2) !== 16'd9) begin n_err++; $display("[TB] FAIL 3x3_elem22: got %h required 0009", elem(got, 2, 2)); end
    n_cmp++;
    if (elem(got, 0, 0) !== 16'd1 || elem(got, 0, 5) !== 16'd1 || elem(got, 5, 5) !== 16'd1) begin
      n_err++; $display("[TB] FAIL 3x3_corners: got %h %h %h required 0001 0001 0001",
                        elem(got, 0, 0), elem(got, 0, 5), elem(got, 5, 5));
    end
    n_cmp++;
    if (elem(got, 1, 2) !== 16'd6) begin n_err++; $display("[TB] FAIL 3x3_elem12: got %h required 0006", elem(got, 1, 2)); end
    release_result();
  endtask

  task automatic test_stride2();
    start_pass(3'd1, 3'd1, 3'd2);
    send_tile(fill_tile(16'd1), 1'b0, 0, 0, 2);
    exp_q.push_back(model_flat());
    wait_result(got, got_ok);
    pop_expected(expv);
    n_cmp++;
    if (!got_ok || got !== expv) begin n_err++; $display("[TB] FAIL stride2_tile: got %h required %h", got, expv); end
    n_cmp++;
    if (elem(got, 4, 4) !== 16'd1 || elem(got, 2, 0) !== 16'd1) begin
      n_err++; $display("[TB] FAIL stride2_even: got %h %h required 0001 0001", elem(got, 4, 4), elem(got, 2, 0));
    end
    n_cmp++;
    if (elem(got, 1, 1) !== 16'd0 || elem(got, 5, 4) !== 16'd0) begin
      n_err++; $display("[TB] FAIL stride2_odd: got %h %h required 0000 0000", elem(got, 1, 1), elem(got, 5, 4));
    end
    release_result();
  endtask

  // kernel_height 0 clamps to 1, kernel_width 7 to 3, stride 0 acts as 1.
  task automatic test_clamp();
    logic [TW-1:0] t;
    start_pass(3'd0, 3'd7, 3'd0);
    for (int kw = 0; kw < 3; kw++) begin
      t = rand_tile();
      send_tile(t, 1'b0, 0, kw, 1);
      if (kw == 1) begin
        n_cmp++;
        if (busy !== 1'b1 || in_valid !== 1'b0) begin
          n_err++; $display("[TB] FAIL clamp_midpass: got busy=%b in_valid=%b required 1 0", busy, in_valid);
        end
      end
    end
    exp_q.push_back(model_flat());
    n_cmp++;
    if (in_valid !== 1'b1) begin n_err++; $display("[TB] FAIL clamp_done: got in_valid=%b required 1", in_valid); end
    wait_result(got, got_ok);
    pop_expected(expv);
    n_cmp++;
    if (!got_ok || got !== expv) begin n_err++; $display("[TB] FAIL clamp_tile: got %h required %h", got, expv); end
    release_result();
  endtask

  task automatic test_backpressure();
    bit stable;
    start_pass(3'd2, 3'd2, 3'd1);
    for (int kh = 0; kh < 2; kh++)
      for (int kw = 0; kw < 2; kw++)
        send_tile(rand_tile(), 1'b1, kh, kw, 1);
    exp_q.push_back(model_flat());
    wait_result(got, got_ok);
    stable = got_ok;
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      if (in_valid !== 1'b1 || in_vals !== got || out_ready !== 1'b0) stable = 1'b0;
    end
    n_cmp++;
    if (!stable) begin n_err++; $display("[TB] FAIL bp_hold_stable: got unstable/dropped in_valid required held"); end
    pop_expected(expv);
    n_cmp++;
    if (!got_ok || got !== expv) begin n_err++; $display("[TB] FAIL bp_tile: got %h required %h", got, expv); end
    release_result();
    n_cmp++;
    if (in_valid !== 1'b0) begin n_err++; $display("[TB] FAIL bp_release: got in_valid=%b required 0", in_valid); end
  endtask

  task automatic test_reset_midpass();
    logic [TW-1:0] tiles [9];
    for (int k = 0; k < 9; k++) tiles[k] = rand_tile();
    start_pass(3'd3, 3'd3, 3'd1);
    for (int k = 0; k < 4; k++) send_tile(tiles[k], 1'b0, k / 3, k % 3, 1);
    n_cmp++;
    if (busy !== 1'b1 || out_ready !== 1'b1) begin
      n_err++; $display("[TB] FAIL midpass_active: got busy=%b out_ready=%b required 1 1", busy, out_ready);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (out_ready !== 1'b0 || in_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("[TB] FAIL midpass_async_reset: got out_ready=%b in_valid=%b busy=%b required 0 0 0",
                        out_ready, in_valid, busy);
    end
    n_cmp++;
    if (in_vals !== {AW{1'b0}}) begin n_err++; $display("[TB] FAIL midpass_acc_clear: got %h required 0", in_vals); end
    @(negedge clock);
    reset = 1'b0;
    start_pass(3'd3, 3'd3, 3'd1);
    for (int k = 0; k < 9; k++) send_tile(tiles[k], 1'b0, k / 3, k % 3, 1);
    exp_q.push_back(model_flat());
    wait_result(got, got_ok);
    pop_expected(expv);
    n_cmp++;
    if (!got_ok || got !== expv) begin n_err++; $display("[TB] FAIL midpass_clean_rerun: got %h required %h", got, expv); end
    release_result();
  endtask

  task automatic test_wrap();
    logic [BL-1:0] req;
`ifdef MPE_OUT2IN_SAT_EN
    req = 16'h7FFF;
`else
    req = 16'hE000;
`endif
    start_pass(3'd2, 3'd1, 3'd1);
    send_tile(fill_tile(16'h7000), 1'b0, 0, 0, 1);
    send_tile(fill_tile(16'h7000), 1'b0, 1, 0, 1);
    exp_q.push_back(model_flat());
    wait_result(got, got_ok);
    pop_expected(expv);
    n_cmp++;
    if (!got_ok || got !== expv) begin n_err++; $display("[TB] FAIL wrap_tile: got %h required %h", got, expv); end
    n_cmp++;
    if (elem(got, 1, 0) !== req) begin n_err++; $display("[TB] FAIL wrap_elem10: got %h required %h", elem(got, 1, 0), req); end
    n_cmp++;
    if (elem(got, 0, 0) !== 16'h7000) begin n_err++; $display("[TB] FAIL wrap_elem00: got %h required 7000", elem(got, 0, 0)); end
    release_result();
  endtask

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    kernel_height = 3'd1;
    kernel_width  = 3'd1;
    stride        = 3'd1;
    out_vals      = '0;
    out_valid     = 1'b0;
    in_ready      = 1'b0;
    model_clear();
    test_reset();
    test_1x1();
    test_3x3();
    test_stride2();
    test_clamp();
    test_backpressure();
    test_reset_midpass();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
